// File: rtl/bch_31_pkg.sv
// Shared constants, FSM state type and GF(2^5) helper for the BCH(31) decode path.
// Field polynomial x^5 + x^2 + 1 doubles as the code generator polynomial.
package bch_31_pkg;

    localparam int unsigned BCH_N = 31;
    localparam int unsigned BCH_M = 5;

    // Reduction term for x^5 = x^2 + 1
    localparam logic [BCH_M-1:0] GF_POLY = 5'b00101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } bch_arb_state_t;

    function automatic logic [BCH_M-1:0] gf_alpha_pow(input int unsigned e);
        logic [BCH_M-1:0] v;
        v = 5'd1;
        for (int unsigned k = 0; k < BCH_N; k++) begin
            if (k < e) begin
                v = {v[BCH_M-2:0], 1'b0} ^ (v[BCH_M-1] ? GF_POLY : 5'd0);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/bch_31_rr_arb.sv
// Two-way combinational round-robin grant; on a tie the requester not served last wins.
module bch_31_rr_arb (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o,
    output logic       grant_idx_o
);

    always_comb begin
        grant_idx_o = (valid_i[0] && valid_i[1]) ? ~last_i : valid_i[1];
        grant_o     = 2'b00;
        if (|valid_i) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/bch_31_top.sv
// Combinational single-error-correcting BCH(31) decoder (generator x^5 + x^2 + 1).
// The syndrome is r(alpha); a nonzero syndrome alpha^i flags an error at bit i.
module bch_31_top
    import bch_31_pkg::*;
(
    input  logic [BCH_N-1:0] codeword_i,
    output logic [BCH_N-1:0] corrected_codeword_o,
    output logic             error_detected
);

    logic [BCH_M-1:0] syndrome;
    logic [BCH_N-1:0] flip;

    always_comb begin
        syndrome = '0;
        for (int unsigned i = 0; i < BCH_N; i++) begin
            if (codeword_i[i]) begin
                syndrome = syndrome ^ gf_alpha_pow(i);
            end
        end
        // alpha is primitive, so every nonzero syndrome matches exactly one position
        flip = '0;
        for (int unsigned i = 0; i < BCH_N; i++) begin
            if (syndrome == gf_alpha_pow(i)) begin
                flip[i] = 1'b1;
            end
        end
        corrected_codeword_o = codeword_i ^ flip;
        error_detected       = |syndrome;
    end

endmodule

// File: rtl/bch_31_dec_arb.sv
// Two-requester round-robin front end for the BCH(31) decoder with registered input and
// output stages, a valid/ready result channel and a saturating error-word counter.
module bch_31_dec_arb
    import bch_31_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [BCH_N-1:0]   req0_codeword,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [BCH_N-1:0]   req1_codeword,
    output logic               req1_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BCH_N-1:0]   out_codeword,
    output logic               out_src,
    output logic               out_err,
    output logic [CNT_W-1:0]   err_count,
    input  logic               clear_count
);

    bch_arb_state_t   state_q, state_d;
    logic             last_q, last_d;
    logic [BCH_N-1:0] cw_q, cw_d;
    logic             src_q, src_d;
    logic             out_valid_q, out_valid_d;
    logic [BCH_N-1:0] out_codeword_q, out_codeword_d;
    logic             out_src_q, out_src_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic [1:0]       grant;
    logic             grant_idx;
    logic [BCH_N-1:0] dec_codeword;
    logic             dec_err;

    bch_31_rr_arb u_arb (
        .valid_i     ({req1_valid, req0_valid}),
        .last_i      (last_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    bch_31_top u_dec (
        .codeword_i           (cw_q),
        .corrected_codeword_o (dec_codeword),
        .error_detected       (dec_err)
    );

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        cw_d           = cw_q;
        src_d          = src_q;
        out_valid_d    = out_valid_q;
        out_codeword_d = out_codeword_q;
        out_src_d      = out_src_q;
        out_err_d      = out_err_q;
        err_count_d    = err_count_q;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Readies are held low during reset so no handshake is implied
                if (!rst && (|grant)) begin
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    cw_d       = grant[1] ? req1_codeword : req0_codeword;
                    src_d      = grant_idx;
                    last_d     = grant_idx;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                out_codeword_d = dec_codeword;
                out_err_d      = dec_err;
                out_src_d      = src_q;
                out_valid_d    = 1'b1;
                state_d        = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (out_err_q && (err_count_q != {CNT_W{1'b1}})) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_count) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_q         <= 1'b1;
            cw_q           <= '0;
            src_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_codeword_q <= '0;
            out_src_q      <= 1'b0;
            out_err_q      <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            cw_q           <= cw_d;
            src_q          <= src_d;
            out_valid_q    <= out_valid_d;
            out_codeword_q <= out_codeword_d;
            out_src_q      <= out_src_d;
            out_err_q      <= out_err_d;
            err_count_q    <= err_count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_codeword = out_codeword_q;
    assign out_src      = out_src_q;
    assign out_err      = out_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_bch_31_dec_arb.sv
// Bench for bch_31_dec_arb: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model using polynomial division for the decode reference.
module tb_bch_31_dec_arb;

    localparam int unsigned CNT_W = 2;
    localparam logic [30:0] GEN   = 31'b100101;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [30:0] req0_codeword;
    logic        req0_ready;
    logic        req1_valid;
    logic [30:0] req1_codeword;
    logic        req1_ready;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] out_codeword;
    logic        out_src;
    logic        out_err;
    logic [CNT_W-1:0] err_count;
    logic        clear_count;

    bch_31_dec_arb #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_codeword (req0_codeword),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_codeword (req1_codeword),
        .req1_ready    (req1_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_codeword  (out_codeword),
        .out_src       (out_src),
        .out_err       (out_err),
        .err_count     (err_count),
        .clear_count   (clear_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: one word in flight, with "decoded" marking that its result is on the channel
    bit          m_have;
    bit          m_decoded;
    logic [30:0] m_word;
    bit          m_src;
    bit          m_last;
    logic        m_ov;
    logic [30:0] m_ocw;
    logic        m_osrc;
    logic        m_oerr;
    int unsigned m_cnt;
    int          src_log[$];

    function automatic logic [4:0] poly_rem(input logic [30:0] r);
        logic [30:0] t;
        t = r;
        for (int i = 30; i >= 5; i--) begin
            if (t[i]) t = t ^ (GEN << (i - 5));
        end
        return t[4:0];
    endfunction

    function automatic logic [30:0] encode(input logic [25:0] msg);
        logic [30:0] t;
        t = {msg, 5'b0};
        return t | {26'b0, poly_rem(t)};
    endfunction

    // Nearest codeword by brute force: the word itself, or the one-bit flip that divides by g
    task automatic ref_fix(input logic [30:0] r, output logic [30:0] cw, output logic err);
        logic [30:0] b;
        cw  = r;
        err = 1'b0;
        if (poly_rem(r) != 5'd0) begin
            err = 1'b1;
            for (int i = 0; i < 31; i++) begin
                b    = 31'd0;
                b[i] = 1'b1;
                if (poly_rem(r ^ b) == 5'd0) cw = r ^ b;
            end
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_decoded = 0; m_word = '0; m_src = 0; m_last = 1;
        m_ov = 0; m_ocw = '0; m_osrc = 0; m_oerr = 0; m_cnt = 0;
    endtask

    task automatic post0(input logic [30:0] w);
        req0_valid = 1'b1;
        req0_codeword = w;
    endtask

    task automatic post1(input logic [30:0] w);
        req1_valid = 1'b1;
        req1_codeword = w;
    endtask

    // Called just after a negedge with inputs set; ends at the next negedge
    task automatic step();
        logic e0, e1, d0, d1;
        logic [30:0] ccw;
        logic cerr;
        #1;
        e0 = !rst && !m_have && req0_valid && (!req1_valid || m_last);
        e1 = !rst && !m_have && req1_valid && (!req0_valid || !m_last);
        check_eq("req0_ready", req0_ready, e0);
        check_eq("req1_ready", req1_ready, e1);
        check_eq("ready_excl", req0_ready & req1_ready, 0);
        check_eq("out_valid", out_valid, m_ov);
        check_eq("out_codeword", out_codeword, m_ocw);
        check_eq("out_src", out_src, m_osrc);
        check_eq("out_err", out_err, m_oerr);
        check_eq("err_count", err_count, m_cnt);
        d0 = req0_valid && req0_ready;
        d1 = req1_valid && req1_ready;
        if (d0) src_log.push_back(0);
        if (d1) src_log.push_back(1);
        if (rst) begin
            model_reset();
        end else begin
            if (!m_have) begin
                if (e0 || e1) begin
                    m_have = 1; m_decoded = 0;
                    m_src  = e1;
                    m_last = e1;
                    m_word = e1 ? req1_codeword : req0_codeword;
                end
            end else if (!m_decoded) begin
                ref_fix(m_word, ccw, cerr);
                m_decoded = 1; m_ov = 1; m_ocw = ccw; m_oerr = cerr; m_osrc = m_src;
            end else if (out_ready) begin
                m_have = 0; m_decoded = 0; m_ov = 0;
                if (m_oerr && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
            if (clear_count) m_cnt = 0;
        end
        @(negedge clk);
        if (d0) req0_valid = 1'b0;
        if (d1) req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req0_valid || req1_valid || m_have) && n < 40) begin
            step();
            n++;
        end
        check_eq("drain_bound", n < 40, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [30:0] rand_word();
        logic [30:0] w;
        w = encode(26'($urandom));
        case ($urandom_range(3))
            0: ;
            1: w[$urandom_range(30)] = ~w[$urandom_range(30)];
            2: begin
                w[$urandom_range(30)] = 1'b1;
                w[$urandom_range(30)] = ~w[$urandom_range(30)];
            end
            default: w = 31'($urandom);
        endcase
        return w;
    endfunction

    logic [CNT_W-1:0] cnt_exp [5];

    initial begin
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_codeword = '0; req1_codeword = '0;
        out_ready = 0; clear_count = 0;
        model_reset();
        @(negedge clk);
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_err_count", err_count, 0);
        @(negedge clk);

        // Clean word from requester 0
        out_ready = 1;
        post0(31'h0);
        step(); step();
        #1;
        check_eq("clean_valid", out_valid, 1);
        check_eq("clean_cw", out_codeword, 31'h0);
        check_eq("clean_err", out_err, 0);
        check_eq("clean_src", out_src, 0);
        step();
        drain();

        // Single-bit error from requester 1
        post1(31'h0000_0001);
        step(); step();
        #1;
        check_eq("sbe_cw", out_codeword, 31'h0);
        check_eq("sbe_err", out_err, 1);
        check_eq("sbe_src", out_src, 1);
        step();
        #1;
        check_eq("sbe_count", err_count, 1);
        drain();

        // Continuous tie: grants alternate starting from 0 (last grant was 1)
        src_log.delete();
        for (int c = 0; c < 12; c++) begin
            if (!req0_valid) post0(31'h0);
            if (!req1_valid) post1(31'h4000_0000);
            step();
        end
        drain();
        check_eq("tie_count", src_log.size() >= 4, 1);
        if (src_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check_eq("tie_order", src_log[i], i % 2);
        end

        // Backpressure in HOLD
        pulse_reset();
        out_ready = 0;
        post0(31'h0000_0005);
        step(); step();
        post0(31'h0000_0022);
        for (int c = 0; c < 6; c++) begin
            #1;
            check_eq("bp_hold_ready", req0_ready, 0);
            step();
        end
        out_ready = 1;
        step();
        #1;
        check_eq("bp_ready_after", req0_ready, 1);
        drain();

        // Counter saturation and clear on the same cycle as an error handshake
        pulse_reset();
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            post0(31'h1 << (k + 3));
            step(); step(); step();
            #1;
            check_eq("cnt_sat", err_count, cnt_exp[k]);
        end
        post0(31'h0000_0100);
        step(); step();
        clear_count = 1;
        step();
        clear_count = 0;
        #1;
        check_eq("cnt_clear", err_count, 0);
        drain();

        // Reset during DECODE, then during HOLD
        out_ready = 0;
        post0(31'h0000_0007);
        step();
        pulse_reset();
        #1;
        check_eq("rst_dec_valid", out_valid, 0);
        step(); step(); step();
        post0(31'h0000_0009);
        step(); step();
        pulse_reset();
        #1;
        check_eq("rst_hold_valid", out_valid, 0);
        check_eq("rst_hold_cw", out_codeword, 0);
        out_ready = 1;
        src_log.delete();
        if (!req0_valid) post0(31'h0);
        post1(31'h0000_0001);
        step();
        check_eq("rst_tie_first", (src_log.size() > 0) ? src_log[0] : 99, 0);
        drain();

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            rst         = ($urandom_range(99) == 0);
            clear_count = ($urandom_range(24) == 0);
            out_ready   = ($urandom_range(2) != 0);
            if (!req0_valid && $urandom_range(1) == 1) post0(rand_word());
            if (!req1_valid && $urandom_range(1) == 1) post1(rand_word());
            step();
        end
        rst = 0; clear_count = 0; out_ready = 1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bch_31_dec_arb.md
# bch_31_dec_arb

Two-requester front end for the shared BCH(31) decoder datapath (`bch_31_top`). It arbitrates round-robin between two codeword sources and registers the accepted codeword in front of the combinational decoder. It registers the corrected result behind the decoder and presents it on a valid/ready output channel tagged with its source. It also maintains a saturating count of decoded words in which errors were found, for status readout.

## Interface

Parameters:
- `CNT_W`, default 16: width of the error-word counter.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req0_valid`  input  1  requester 0 holds a codeword.
- `req0_codeword`  input  31  requester 0 codeword.
- `req0_ready`  output  1  requester 0 codeword accepted this cycle.
- `req1_valid`  input  1  requester 1 holds a codeword.
- `req1_codeword`  input  31  requester 1 codeword.
- `req1_ready`  output  1  requester 1 codeword accepted this cycle.
- `out_valid`  output  1  result held on the output channel.
- `out_ready`  input  1  consumer accepts the result.
- `out_codeword`  output  31  corrected codeword.
- `out_src`  output  1  requester index of the result.
- `out_err`  output  1  decoder's `error_detected` for this word.
- `err_count`  output  CNT_W  number of delivered words with `out_err`=1, saturating.
- `clear_count`  input  1  synchronous clear of `err_count`.

## Operation

- FSM states are IDLE, DECODE and HOLD. Reset enters IDLE.
- **IDLE:**
  - If any `reqN_valid` is high, grant one requester and pulse its `reqN_ready` for 1 cycle. That handshake loads `cw_q` and `src_q`; the next state is DECODE.
  - If no requester is valid, stay in IDLE.
- **Arbitration:**
  - `last_q` holds the index of the previously granted requester.
  - When both requesters are valid, grant `!last_q`. A single valid requester is granted regardless of `last_q`.
  - Reset sets `last_q`=1, so requester 0 wins the first tie.
  - `last_q` updates only on a grant.
- **Ready rules:**
  - `reqN_ready` is combinational from the state, `last_q` and both `reqN_valid` inputs. It never depends on `out_ready`.
  - At most one `reqN_ready` is high per cycle, and only in IDLE.
- **Requester obligation:** once `reqN_valid` is high it stays high, with `reqN_codeword` stable, until `reqN_ready`.
- **DECODE:**
  - `bch_31_top` is driven from `cw_q`.
  - Register `out_codeword` = `corrected_codeword_o`, `out_err` = `error_detected` and `out_src` = `src_q`.
  - Set `out_valid`; the next state is HOLD.
- **HOLD:**
  - `out_valid`=1, and all output fields stay stable until `out_ready`.
  - On the handshake: clear `out_valid` and go to IDLE. If `out_err` is 1, increment `err_count`.
- **`err_count`:**
  - Increments by 1 per delivered error word and saturates at all-ones (no wrap).
  - `clear_count` sets it to 0. A clear and an increment in the same cycle yield 0.
- **Reset:**
  - Values: `out_valid`=0, `out_codeword`=0, `out_src`=0, `out_err`=0, `err_count`=0, `req0_ready`=0, `req1_ready`=0, state IDLE, `last_q`=1.
  - Reset in any state discards the in-flight word; no output handshake occurs for it.

## Timing

- Accept handshake in cycle N: `out_valid` rises in cycle N+2, i.e. one cycle in DECODE, visible from HOLD.
- With `out_ready` held high, one word is delivered every 3 cycles: IDLE, DECODE, HOLD.
- The critical path is the full combinational `bch_31_top` between `cw_q` and the output registers. Both ends are registered in this block.
- `err_count` reflects an error-word handshake from the cycle after that handshake.

## Structure

- Package `bch_31_pkg` holds:
  - `BCH_N` = 31.
  - The state enum `bch_arb_state_t` {IDLE, DECODE, HOLD}.
- Sub-module `bch_31_rr_arb`: a 2-way combinational round-robin grant. Inputs are the valids and `last_q`; outputs are a one-hot grant and the granted index.
- One `bch_31_top` instance is embedded.
- The FSM, registers and counter live in the top of this block.

## Test plan

- **Clean word:** after reset, `req0_codeword`=31'h0 with `out_ready`=1 → `req0_ready` pulses at N, then at N+2 `out_codeword`=31'h0, `out_err`=0, `out_src`=0, and `err_count` stays 0.
- **Single-bit error:** `req1_codeword`=31'h0000_0001 → `out_codeword`=31'h0, `out_err`=1, `out_src`=1, and `err_count`=1 the cycle after the handshake.
- **Tie/fairness:** both requesters valid continuously with distinct words (0 and 31'h4000_0000) → grants alternate 0,1,0,1. Each `out_src` matches its word, and no two readies are high in one cycle.
- **Backpressure:** hold `out_ready`=0 for 6 cycles in HOLD while `req0_valid`=1 → outputs stable and `req0_ready`=0 throughout. Raise `out_ready` → handshake, then `req0_ready` in the following cycle.
- **Counter:** `CNT_W`=2, deliver 5 single-error words → `err_count` = 1, 2, 3, 3, 3. Assert `clear_count` in the same cycle as a 6th error handshake → `err_count`=0.
- **Reset mid-operation:** assert `rst` in DECODE, then in HOLD → all outputs at reset values the next cycle, and no spurious `out_valid`. After reset, a tie goes to requester 0.
